// File: rtl/afpm_operand_deserializer_if.sv
// Byte-serial operand link into the FP16 log-multiplier core.
// master drives beats and accepts pairs; slave is the deserializer.
interface afpm_operand_deserializer_if #(
    parameter int ERR_W = 8
);
    logic             ena;
    logic             byte_valid;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic             in_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       a_cls;
    logic [1:0]       b_cls;
    logic             sync_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output ena, byte_valid, a_byte, b_byte, op_ready,
        input  in_ready, op_a, op_b, op_valid,
        input  a_cls, b_cls, sync_err, err_cnt
    );

    modport slave (
        input  ena, byte_valid, a_byte, b_byte, op_ready,
        output in_ready, op_a, op_b, op_valid,
        output a_cls, b_cls, sync_err, err_cnt
    );
endinterface

// File: rtl/afpm_operand_deserializer.sv
// Two-beat operand assembler with one staging slot, beat timeout,
// saturating framing-error counter and FP16 special-value tagging.
module afpm_operand_deserializer #(
    parameter int LSB_FIRST = 1,
    parameter int TIMEOUT   = 16,
    parameter int ERR_W     = 8
) (
    input logic clk,
    input logic rst,
    afpm_operand_deserializer_if.slave bus
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {LO, HI, HOLD} state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [7:0]       half_a, half_b;
    logic [15:0]      stg_a, stg_b;
    logic [15:0]      op_a, op_b;
    logic             op_valid;
    logic             sync_err;
    logic [ERR_W-1:0] err_cnt;

    logic        in_ready, beat, accept, drop, drain;
    logic        ld_half, ld_out, ld_stg, stg_to_out, tmo;
    logic [15:0] word_a, word_b;

    function automatic logic [1:0] fp16_cls(input logic [15:0] v);
        logic [1:0] c;
        c = 2'b00;
        if (v[14:10] == 5'd0 && v[9:0] == 10'd0)
            c = 2'b01;
        else if (v[14:10] == 5'h1f && v[9:0] == 10'd0)
            c = 2'b10;
        else if (v[14:10] == 5'h1f)
            c = 2'b11;
        return c;
    endfunction

    assign in_ready = (state != HOLD);
    assign beat     = bus.byte_valid & bus.ena;
    assign accept   = beat & in_ready;
    assign drop     = beat & ~in_ready;
    assign drain    = op_valid & bus.op_ready;

    // Join the stored first beat with the current one in wire order.
    always_comb begin
        word_a = {bus.a_byte, half_a};
        word_b = {bus.b_byte, half_b};
        if (LSB_FIRST == 0) begin
            word_a = {half_a, bus.a_byte};
            word_b = {half_b, bus.b_byte};
        end
    end

    // Next-state, timer and datapath load strobes.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        ld_half    = 1'b0;
        ld_out     = 1'b0;
        ld_stg     = 1'b0;
        stg_to_out = 1'b0;
        tmo        = 1'b0;
        unique case (state)
            LO: begin
                if (accept) begin
                    ld_half  = 1'b1;
                    timer_nx = '0;
                    state_nx = HI;
                end
            end
            HI: begin
                if (accept) begin
                    timer_nx = '0;
                    if (!op_valid || drain) begin
                        ld_out   = 1'b1;
                        state_nx = LO;
                    end else begin
                        ld_stg   = 1'b1;
                        state_nx = HOLD;
                    end
                end else if (bus.ena) begin
                    if (timer == TW'(TIMEOUT - 1)) begin
                        tmo      = 1'b1;
                        timer_nx = '0;
                        state_nx = LO;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    stg_to_out = 1'b1;
                    state_nx   = LO;
                end
            end
            default: state_nx = LO;
        endcase
    end

    // State and beat timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LO;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // First-beat halves, staging slot and output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_a   <= '0;
            half_b   <= '0;
            stg_a    <= '0;
            stg_b    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
        end else begin
            if (ld_half) begin
                half_a <= bus.a_byte;
                half_b <= bus.b_byte;
            end
            if (ld_stg) begin
                stg_a <= word_a;
                stg_b <= word_b;
            end
            if (ld_out) begin
                op_a     <= word_a;
                op_b     <= word_b;
                op_valid <= 1'b1;
            end else if (stg_to_out) begin
                op_a     <= stg_a;
                op_b     <= stg_b;
                op_valid <= 1'b1;
            end else if (drain) begin
                op_valid <= 1'b0;
            end
        end
    end

    // Framing-error pulse and saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            sync_err <= tmo | drop;
            if ((tmo || drop) && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;
    assign bus.op_valid = op_valid;
    assign bus.a_cls    = fp16_cls(op_a);
    assign bus.b_cls    = fp16_cls(op_b);
    assign bus.sync_err = sync_err;
    assign bus.err_cnt  = err_cnt;
endmodule
